// File: rtl/etapa_filtros.sv
// -----------------------------------------------------------------------------
// etapa_filtros
//   Three-band filter stage: low-pass (bajos), band-pass (medios) and
//   high-pass (altos) Direct-Form-I biquads that share one input sample and
//   one sample strobe. Each band produces its registered output on the same
//   edge that samples its input (one clock latency).
//
//   Ports
//     clock_In        : clock, all state changes on the rising edge
//     Reset           : synchronous active-high reset, has priority over enable
//     enable          : sample strobe, one sample per enabled edge
//     Data_In         : input sample, signed Q9.14
//     Data_Out_bajos  : low-pass output, signed Q9.14, registered
//     Data_Out_medios : band-pass output, signed Q9.14, registered
//     Data_Out_altos  : high-pass output, signed Q9.14, registered
//
//   Coefficients are packed {b0,b1,b2,a1,a2}, 23 bits each, signed Q9.14.
// -----------------------------------------------------------------------------
module etapa_filtros #(
    parameter int           FRAC        = 14,
    parameter logic [114:0] COEF_BAJOS  = {23'h001000, 23'h002000, 23'h001000, 23'h0, 23'h0},
    parameter logic [114:0] COEF_MEDIOS = {23'h002000, 23'h0, 23'h7FE000, 23'h0, 23'h0},
    parameter logic [114:0] COEF_ALTOS  = {23'h001000, 23'h7FE000, 23'h001000, 23'h0, 23'h0}
) (
    input  logic        clock_In,
    input  logic        Reset,
    input  logic        enable,
    input  logic [22:0] Data_In,
    output logic [22:0] Data_Out_bajos,
    output logic [22:0] Data_Out_medios,
    output logic [22:0] Data_Out_altos
);

    localparam int NUM_BANDS = 3;
    localparam logic [NUM_BANDS-1:0][114:0] COEFS = {COEF_ALTOS, COEF_MEDIOS, COEF_BAJOS};

    logic [NUM_BANDS-1:0][22:0] y_out;

    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
        etapa_filtros_biquad #(
            .FRAC (FRAC),
            .COEF (COEFS[g])
        ) u_biquad (
            .clk    (clock_In),
            .rst    (Reset),
            .en     (enable),
            .x_in   (Data_In),
            .y_out  (y_out[g])
        );
    end

    assign Data_Out_bajos  = y_out[0];
    assign Data_Out_medios = y_out[1];
    assign Data_Out_altos  = y_out[2];

endmodule

// -----------------------------------------------------------------------------
// etapa_filtros_biquad
//   One Direct-Form-I biquad band:
//     y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
//   Full 46-bit products, 49-bit accumulation, arithmetic shift by FRAC
//   (floor), saturation to 23-bit signed.
//
//   Ports
//     clk   : clock
//     rst   : synchronous active-high reset
//     en    : sample strobe
//     x_in  : input sample, signed Q9.14
//     y_out : registered output, signed Q9.14
// -----------------------------------------------------------------------------
module etapa_filtros_biquad #(
    parameter int           FRAC = 14,
    parameter logic [114:0] COEF = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [22:0] x_in,
    output logic [22:0] y_out
);

    localparam logic signed [22:0] B0 = COEF[114:92];
    localparam logic signed [22:0] B1 = COEF[91:69];
    localparam logic signed [22:0] B2 = COEF[68:46];
    localparam logic signed [22:0] A1 = COEF[45:23];
    localparam logic signed [22:0] A2 = COEF[22:0];

    localparam logic signed [48:0] Y_MAX = 49'sd4194303;
    localparam logic signed [48:0] Y_MIN = -49'sd4194304;

    // Signed 23x23 product at full 46-bit precision, sign-extended to the
    // 49-bit accumulator width.
    function automatic logic signed [48:0] mul_ext(input logic [22:0] a, input logic [22:0] b);
        logic signed [45:0] a_e;
        logic signed [45:0] b_e;
        logic signed [45:0] p;
        a_e = {{23{a[22]}}, a};
        b_e = {{23{b[22]}}, b};
        p   = a_e * b_e;
        return {{3{p[45]}}, p};
    endfunction

    // y1 doubles as the output register: the saturated result is both.
    logic [22:0] x1_q, x1_d;
    logic [22:0] x2_q, x2_d;
    logic [22:0] y1_q, y1_d;
    logic [22:0] y2_q, y2_d;

    logic signed [48:0] acc;
    logic signed [48:0] acc_sh;
    logic        [22:0] y_sat;

    always_comb begin
        acc = mul_ext(B0, x_in) + mul_ext(B1, x1_q) + mul_ext(B2, x2_q)
            - mul_ext(A1, y1_q) - mul_ext(A2, y2_q);
        acc_sh = acc >>> FRAC;
        if (acc_sh > Y_MAX) begin
            y_sat = 23'h3FFFFF;
        end else if (acc_sh < Y_MIN) begin
            y_sat = 23'h400000;
        end else begin
            y_sat = acc_sh[22:0];
        end
    end

    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        y1_d = y1_q;
        y2_d = y2_q;
        if (en) begin
            x2_d = x1_q;
            x1_d = x_in;
            y2_d = y1_q;
            y1_d = y_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
        end
    end

    assign y_out = y1_q;

endmodule

// File: tb/tb_etapa_filtros.sv
// -----------------------------------------------------------------------------
// tb_etapa_filtros
//   Directed bench for etapa_filtros. A default-coefficient instance covers
//   reset, impulse, DC step, hold and mid-stream reset; a second instance with
//   low-pass b0 = 2.0 covers saturation. Each step pushes its expected outputs
//   to a queue before the edge and pops/compares them one edge later.
// -----------------------------------------------------------------------------
module tb_etapa_filtros;

    logic        clk;
    logic        rst;
    logic        en;
    logic [22:0] din;
    logic        en_s;
    logic [22:0] din_s;
    logic [22:0] out_b, out_m, out_a;
    logic [22:0] sat_b, sat_m, sat_a;

    typedef struct {
        string       tag;
        logic [22:0] b;
        logic [22:0] m;
        logic [22:0] a;
        logic [22:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    etapa_filtros dut (
        .clock_In        (clk),
        .Reset           (rst),
        .enable          (en),
        .Data_In         (din),
        .Data_Out_bajos  (out_b),
        .Data_Out_medios (out_m),
        .Data_Out_altos  (out_a)
    );

    etapa_filtros #(
        .COEF_BAJOS ({23'h008000, 23'h0, 23'h0, 23'h0, 23'h0})
    ) dut_sat (
        .clock_In        (clk),
        .Reset           (rst),
        .enable          (en_s),
        .Data_In         (din_s),
        .Data_Out_bajos  (sat_b),
        .Data_Out_medios (sat_m),
        .Data_Out_altos  (sat_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one edge on both instances and check the outputs it produces.
    task automatic step(input string tag,
                        input logic r, input logic e, input logic [22:0] d,
                        input logic es, input logic [22:0] ds,
                        input logic [22:0] eb, input logic [22:0] em,
                        input logic [22:0] ea, input logic [22:0] esb);
        exp_t x;
        exp_t got;
        rst   = r;
        en    = e;
        din   = d;
        en_s  = es;
        din_s = ds;
        x.tag = tag; x.b = eb; x.m = em; x.a = ea; x.s = esb;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({got.tag, " bajos"},  out_b, got.b);
        chk({got.tag, " medios"}, out_m, got.m);
        chk({got.tag, " altos"},  out_a, got.a);
        chk({got.tag, " sat"},    sat_b, got.s);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = '0; en_s = 1'b0; din_s = '0;
        @(posedge clk);
        #1;
        chk("reset_state bajos",  out_b, 23'h0);
        chk("reset_state medios", out_m, 23'h0);
        chk("reset_state altos",  out_a, 23'h0);
        chk("reset_state sat",    sat_b, 23'h0);

        // Reset wins over enable; the presented sample is discarded.
        step("rst_en",    1, 1, 23'h004000, 1, 23'h300000, 23'h0, 23'h0, 23'h0, 23'h0);
        step("post_rst0", 0, 1, 23'h000000, 0, 23'h0,      23'h0, 23'h0, 23'h0, 23'h0);

        // Impulse
        step("imp0", 0, 1, 23'h004000, 0, 23'h0, 23'h001000, 23'h002000, 23'h001000, 23'h0);
        step("imp1", 0, 1, 23'h000000, 0, 23'h0, 23'h002000, 23'h000000, 23'h7FE000, 23'h0);
        step("imp2", 0, 1, 23'h000000, 0, 23'h0, 23'h001000, 23'h7FE000, 23'h001000, 23'h0);
        step("imp3", 0, 1, 23'h000000, 0, 23'h0, 23'h000000, 23'h000000, 23'h000000, 23'h0);

        // DC step
        step("dc_rst", 1, 0, 23'h0, 0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0);
        step("dc0", 0, 1, 23'h004000, 0, 23'h0, 23'h001000, 23'h002000, 23'h001000, 23'h0);
        step("dc1", 0, 1, 23'h004000, 0, 23'h0, 23'h003000, 23'h002000, 23'h7FF000, 23'h0);
        step("dc2", 0, 1, 23'h004000, 0, 23'h0, 23'h004000, 23'h000000, 23'h000000, 23'h0);
        step("dc3", 0, 1, 23'h004000, 0, 23'h0, 23'h004000, 23'h000000, 23'h000000, 23'h0);

        // Hold with enable low and Data_In changing
        step("hold_rst", 1, 0, 23'h0, 0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0);
        step("hold_imp0", 0, 1, 23'h004000, 0, 23'h0, 23'h001000, 23'h002000, 23'h001000, 23'h0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold%0d", i), 0, 0, 23'($urandom), 0, 23'($urandom),
                 23'h001000, 23'h002000, 23'h001000, 23'h0);
        end
        step("hold_resume", 0, 1, 23'h000000, 0, 23'h0, 23'h002000, 23'h000000, 23'h7FE000, 23'h0);

        // Saturation on the b0 = 2.0 instance; main instance holds
        step("sat_pos", 0, 0, 23'h0, 1, 23'h300000, 23'h002000, 23'h000000, 23'h7FE000, 23'h3FFFFF);
        step("sat_neg", 0, 0, 23'h0, 1, 23'h500000, 23'h002000, 23'h000000, 23'h7FE000, 23'h400000);
        step("sat_lin", 0, 0, 23'h0, 1, 23'h001000, 23'h002000, 23'h000000, 23'h7FE000, 23'h002000);

        // Reset mid-stream restarts the DC step
        step("mid_rst", 1, 0, 23'h0, 0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0);
        step("mid0", 0, 1, 23'h004000, 0, 23'h0, 23'h001000, 23'h002000, 23'h001000, 23'h0);
        step("mid1", 0, 1, 23'h004000, 0, 23'h0, 23'h003000, 23'h002000, 23'h7FF000, 23'h0);
        step("mid_r", 1, 1, 23'h004000, 0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0);
        step("mid2", 0, 1, 23'h004000, 0, 23'h0, 23'h001000, 23'h002000, 23'h001000, 23'h0);
        step("mid3", 0, 1, 23'h004000, 0, 23'h0, 23'h003000, 23'h002000, 23'h7FF000, 23'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/etapa_filtros.md
ETAPA_FILTROS -- requirements
Module: etapa_filtros

Interface
Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL expose the following parameters:
- FRAC, 14, fractional bits of all samples and coefficients (signed two's complement Q9.14).
- COEF_BAJOS, {23'h001000,23'h002000,23'h001000,23'h0,23'h0}, low-pass coefficients packed {b0,b1,b2,a1,a2}, 115 bits.
- COEF_MEDIOS, {23'h002000,23'h0,23'h7FE000,23'h0,23'h0}, band-pass coefficients, same packing.
- COEF_ALTOS, {23'h001000,23'h7FE000,23'h001000,23'h0,23'h0}, high-pass coefficients, same packing.

Ports (one per line: name, direction, width, meaning):
REQ-002 The block SHALL expose the following ports:
- clock_In, in, 1, single clock; all state changes on its rising edge.
- Reset, in, 1, synchronous, active-high reset.
- enable, in, 1, sample strobe; one new sample is processed per rising edge with enable=1.
- Data_In, in, 23, input sample, signed Q9.14.
- Data_Out_bajos, out, 23, low-pass output, signed Q9.14, registered.
- Data_Out_medios, out, 23, band-pass output, signed Q9.14, registered.
- Data_Out_altos, out, 23, high-pass output, signed Q9.14, registered.

Function
REQ-003 Each channel SHALL be an independent Direct-Form-I biquad: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2], using its own coefficient set.
REQ-004 All three channels SHALL share the same input sample Data_In and the same enable strobe.
REQ-005 Coefficient products SHALL be full-precision 46-bit signed, and sums SHALL be accumulated in at least 49 bits with no intermediate overflow.
REQ-006 The accumulated sum SHALL be arithmetically right-shifted by FRAC, i.e. truncated toward minus infinity.
REQ-007 The shifted result SHALL be saturated to the 23-bit signed range: above 23'h3FFFFF gives 23'h3FFFFF, below 23'h400000 (-2^22) gives 23'h400000.
REQ-008 The saturated value SHALL be both the output register value and the y[n-1] history entry.
REQ-009 On a rising edge with enable=1 and Reset=0, each channel SHALL do all of the following on that same edge:
- compute y[n] from the current Data_In and its histories;
- load y[n] into its output register;
- shift history: x[n-2]<=x[n-1], x[n-1]<=Data_In, y[n-2]<=y[n-1], y[n-1]<=y[n].
REQ-010 Latency SHALL be one clock: an output is valid after the edge that sampled its input and is stable until the next enabled edge.
REQ-011 On rising edges with enable=0, outputs and all history registers SHALL hold their values; Data_In is ignored.
REQ-012 Consecutive enabled edges (enable held high) SHALL process one sample per clock with no stall or handshake.

Reset
REQ-013 On a rising edge with Reset=1, all three output registers and all x/y history registers SHALL become 0, regardless of enable.
REQ-014 Reset SHALL take priority over enable; a sample presented during reset is discarded.
REQ-015 After Reset deasserts, the first enabled sample SHALL be filtered as if all prior samples were 0.
REQ-016 The block SHALL have no asynchronous reset behaviour.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Reset with enable=1 and Data_In=23'h004000 -> all outputs 0; next enabled sample 0 -> all outputs remain 0.
- Impulse, defaults: enabled samples 23'h004000, 0, 0, 0 -> bajos 001000,002000,001000,000000; medios 002000,000000,7FE000,000000; altos 001000,7FE000,001000,000000.
- DC step, defaults: 23'h004000 held for 4 enabled samples -> bajos 001000,003000,004000,004000; altos 001000,7FF000,000000,000000; medios 002000,002000,000000,000000.
- Hold: after the impulse's first sample, 5 edges with enable=0 and Data_In changing -> outputs stay 001000/002000/001000; resuming with sample 0 gives the second impulse value.
- Saturation, COEF_BAJOS b0=23'h008000 (2.0), others 0: input 23'h300000 -> 3FFFFF; input 23'h500000 -> 400000; input 23'h001000 -> 002000.
- Reset mid-stream: after the 2nd DC-step sample, assert Reset for one edge -> outputs 0; next enabled sample 23'h004000 -> bajos 001000, i.e. the step restarts.
